// File: rtl/laser_link_bridge_pkg.sv
// Shared types and constants for the FTDI<->laser link bridge.
package laser_link_pkg;

    typedef enum logic [1:0] {
        LLB_MODE_IDLE  = 2'b00,
        LLB_MODE_ECHO  = 2'b01,
        LLB_MODE_LASER = 2'b10,
        LLB_MODE_RSVD  = 2'b11
    } llb_mode_t;

    typedef logic [1:0] llb_state_t;

    localparam llb_state_t LLB_ST_IDLE    = 2'd0;
    localparam llb_state_t LLB_ST_CAPTURE = 2'd1;
    localparam llb_state_t LLB_ST_ECHO_WR = 2'd2;
    localparam llb_state_t LLB_ST_TX_SEND = 2'd3;

    // Only ECHO and LASER fetch host bytes; the reserved code behaves as IDLE.
    function automatic logic mode_fetches(input logic [1:0] m);
        return (m == LLB_MODE_ECHO) || (m == LLB_MODE_LASER);
    endfunction

endpackage

// File: rtl/laser_link_bridge_if.sv
// FTDI queue and laser transmitter/receiver signals seen by the bridge.
interface laser_link_bridge_if #(
    parameter int DATA_W = 8
);
    logic              rdq_empty;
    logic [DATA_W-1:0] data_rd;
    logic              rdreq;
    logic              wrq_full;
    logic              wrreq;
    logic [DATA_W-1:0] data_wr;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;

    modport master (
        input  rdq_empty, data_rd, wrq_full, tx_ready, rx_valid, rx_data,
        output rdreq, wrreq, data_wr, tx_valid, tx_data
    );

    modport slave (
        output rdq_empty, data_rd, wrq_full, tx_ready, rx_valid, rx_data,
        input  rdreq, wrreq, data_wr, tx_valid, tx_data
    );
endinterface

// File: rtl/laser_link_bridge_rx_fifo.sv
// Show-ahead synchronous FIFO buffering laser-received bytes for the FTDI write queue.
module llb_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // The extra pointer bit distinguishes a full ring from an empty one.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/laser_link_bridge.sv
// FTDI<->laser datapath controller: host-byte FSM, RX buffering, write-queue arbiter, status.
// Optional statistics counters are built when LLB_STATS_EN is defined.
module laser_link_bridge
    import laser_link_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int RX_FIFO_DEPTH = 4,
    parameter int DROP_CNT_W    = 8,
    parameter int STAT_W        = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic [1:0]            mode,
    laser_link_bridge_if.master   bus,
    output logic [DATA_W-1:0]     last_rx,
    output logic [DATA_W-1:0]     last_tx,
    output logic                  rx_overflow,
    output logic [DROP_CNT_W-1:0] rx_drops,
    output logic [STAT_W-1:0]     tx_count,
    output logic [STAT_W-1:0]     rx_count
);
    llb_state_t        state;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] byte_q;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic              rx_drop;
    logic              fetch;
    logic              echo_wr;
    logic              tx_xfer;

    llb_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (bus.rx_data),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // Full is judged before any same-cycle pop, so a strobe into a full FIFO is always a drop.
    assign fifo_push = bus.rx_valid && !fifo_full;
    assign rx_drop   = bus.rx_valid && fifo_full;

    // Buffered RX data owns the write queue; the echo byte only goes once the FIFO is drained.
    assign fifo_pop = !fifo_empty && !bus.wrq_full;
    assign echo_wr  = (state == LLB_ST_ECHO_WR) && fifo_empty && !bus.wrq_full;

    assign fetch   = !reset && (state == LLB_ST_IDLE) && en && mode_fetches(mode) && !bus.rdq_empty;
    assign tx_xfer = (state == LLB_ST_TX_SEND) && bus.tx_ready;

    assign bus.rdreq    = fetch;
    assign bus.wrreq    = fifo_pop || echo_wr;
    assign bus.data_wr  = fifo_pop ? fifo_head : (echo_wr ? byte_q : '0);
    assign bus.tx_valid = (state == LLB_ST_TX_SEND);
    assign bus.tx_data  = (state == LLB_ST_TX_SEND) ? byte_q : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= LLB_ST_IDLE;
            mode_q  <= LLB_MODE_IDLE;
            last_tx <= '0;
        end else begin
            case (state)
                LLB_ST_IDLE: begin
                    if (fetch) begin
                        mode_q <= mode;
                        state  <= LLB_ST_CAPTURE;
                    end
                end
                LLB_ST_CAPTURE: begin
                    state <= (mode_q == LLB_MODE_ECHO) ? LLB_ST_ECHO_WR : LLB_ST_TX_SEND;
                end
                LLB_ST_ECHO_WR: begin
                    if (echo_wr) state <= LLB_ST_IDLE;
                end
                LLB_ST_TX_SEND: begin
                    if (tx_xfer) begin
                        last_tx <= byte_q;
                        state   <= LLB_ST_IDLE;
                    end
                end
                default: state <= LLB_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (state == LLB_ST_CAPTURE) byte_q <= bus.data_rd;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_rx     <= '0;
            rx_overflow <= 1'b0;
            rx_drops    <= '0;
        end else begin
            if (fifo_push) last_rx <= bus.rx_data;
            if (rx_drop) begin
                rx_overflow <= 1'b1;
                if (rx_drops != {DROP_CNT_W{1'b1}}) rx_drops <= rx_drops + 1'b1;
            end
        end
    end

`ifdef LLB_STATS_EN
    logic [STAT_W-1:0] tx_cnt_q;
    logic [STAT_W-1:0] rx_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (tx_xfer)   tx_cnt_q <= tx_cnt_q + 1'b1;
            if (fifo_push) rx_cnt_q <= rx_cnt_q + 1'b1;
        end
    end

    assign tx_count = tx_cnt_q;
    assign rx_count = rx_cnt_q;
`else
    assign tx_count = '0;
    assign rx_count = '0;
`endif

endmodule
